// File: rtl/count_up_debounce_pkg.sv
// Shared definitions for the push-button debouncer and the CountFSM counter it feeds.
// Holds the state encoding and the counter widths.
package count_up_debounce_pkg;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  localparam int CNT_W = 8;
  localparam int RPT_W = 16;

  typedef enum logic [1:0] {
    IDLE         = ST_IDLE,
    PRESS_WAIT   = ST_PRESS_WAIT,
    PRESSED      = ST_PRESSED,
    RELEASE_WAIT = ST_RELEASE_WAIT
  } db_state_t;

endpackage

// File: rtl/count_up_debounce_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reused for other raw inputs.
// Both flops clear on the synchronous active-high Reset.
module sync_2ff (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic q
);

  logic s1_r;
  logic s2_r;

  // Metastability-settling flop chain.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= d;
      s2_r <= s1_r;
    end
  end

  assign q = s2_r;

endmodule

// File: rtl/count_up_debounce.sv
// Turns a raw bouncing button into a registered one-cycle Count_up strobe for CountFSM,
// with an optional auto-repeat while the button stays held.
module count_up_debounce
  import count_up_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_CYCLES = 0
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Btn_in,
  output logic Count_up,
  output logic Btn_level
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_LAST    =
    (REPEAT_CYCLES == 0) ? {RPT_W{1'b0}} : RPT_W'(REPEAT_CYCLES - 1);
  localparam logic             RPT_EN      = (REPEAT_CYCLES != 0);

  logic             s2_s;
  db_state_t        state_r;
  db_state_t        state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [RPT_W-1:0] rpt_r;
  logic [RPT_W-1:0] rpt_nxt_s;
  logic             count_up_r;
  logic             count_up_nxt_s;
  logic             btn_level_r;
  logic             btn_level_nxt_s;

  sync_2ff u_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (Btn_in),
    .q     (s2_s)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode from the synchronised level and the stability counter.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (s2_s) state_nxt_s = PRESS_WAIT;
        else      state_nxt_s = IDLE;
      end
      PRESS_WAIT: begin
        if (!s2_s)                     state_nxt_s = IDLE;
        else if (cnt_r == STABLE_LAST) state_nxt_s = PRESSED;
        else                           state_nxt_s = PRESS_WAIT;
      end
      PRESSED: begin
        if (!s2_s) state_nxt_s = RELEASE_WAIT;
        else       state_nxt_s = PRESSED;
      end
      RELEASE_WAIT: begin
        if (s2_s)                      state_nxt_s = PRESSED;
        else if (cnt_r == STABLE_LAST) state_nxt_s = IDLE;
        else                           state_nxt_s = RELEASE_WAIT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Counter and output next values; Count_up is a pulse unless a rule sets it this cycle.
  always_comb begin
    cnt_nxt_s       = cnt_r;
    rpt_nxt_s       = rpt_r;
    count_up_nxt_s  = 1'b0;
    btn_level_nxt_s = btn_level_r;
    case (state_r)
      IDLE: begin
        if (s2_s) cnt_nxt_s = {CNT_W{1'b0}};
        else      cnt_nxt_s = cnt_r;
      end
      PRESS_WAIT: begin
        if (!s2_s) begin
          cnt_nxt_s = cnt_r;
        end else if (cnt_r == STABLE_LAST) begin
          count_up_nxt_s  = 1'b1;
          btn_level_nxt_s = 1'b1;
          rpt_nxt_s       = {RPT_W{1'b0}};
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      PRESSED: begin
        // Release beats a coincident repeat expiry, so no pulse on that edge.
        if (!s2_s) begin
          cnt_nxt_s = {CNT_W{1'b0}};
          rpt_nxt_s = {RPT_W{1'b0}};
        end else if (RPT_EN && (rpt_r == RPT_LAST)) begin
          count_up_nxt_s = 1'b1;
          rpt_nxt_s      = {RPT_W{1'b0}};
        end else if (RPT_EN) begin
          rpt_nxt_s = rpt_r + RPT_W'(1);
        end else begin
          rpt_nxt_s = rpt_r;
        end
      end
      RELEASE_WAIT: begin
        if (s2_s) begin
          rpt_nxt_s = {RPT_W{1'b0}};
        end else if (cnt_r == STABLE_LAST) begin
          btn_level_nxt_s = 1'b0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        cnt_nxt_s       = {CNT_W{1'b0}};
        rpt_nxt_s       = {RPT_W{1'b0}};
        btn_level_nxt_s = 1'b0;
      end
    endcase
  end

  // Counter and output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_r       <= {CNT_W{1'b0}};
      rpt_r       <= {RPT_W{1'b0}};
      count_up_r  <= 1'b0;
      btn_level_r <= 1'b0;
    end else begin
      cnt_r       <= cnt_nxt_s;
      rpt_r       <= rpt_nxt_s;
      count_up_r  <= count_up_nxt_s;
      btn_level_r <= btn_level_nxt_s;
    end
  end

  assign Count_up  = count_up_r;
  assign Btn_level = btn_level_r;

endmodule

// File: tb/tb_count_up_debounce.sv
// Self-checking bench: three debouncer configurations against a run-length reference model,
// a hand-written vector table, an auto-repeat sequence and randomised bouncing.
module tb_count_up_debounce;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         btn;
  logic [N-1:0] cu;
  logic [N-1:0] lv;

  int stab [N] = '{4, 4, 1};
  int rptc [N] = '{0, 8, 1};

  int checks   = 0;
  int failures = 0;

  // Reference model: level accepted after STABLE+1 equal samples, repeat every REPEAT held samples.
  int m_lvl [N];
  int m_run [N];
  int m_rep [N];
  bit m_cu  [N];
  bit m_s1;
  bit m_s2;

  typedef struct {
    bit r;
    bit b;
    bit cu;
    bit lv;
  } vec_t;
  vec_t vecs[$];

  count_up_debounce #(.STABLE_CYCLES(4), .REPEAT_CYCLES(0)) dut0 (
    .Clk(clk), .Reset(rst), .Btn_in(btn), .Count_up(cu[0]), .Btn_level(lv[0]));
  count_up_debounce #(.STABLE_CYCLES(4), .REPEAT_CYCLES(8)) dut1 (
    .Clk(clk), .Reset(rst), .Btn_in(btn), .Count_up(cu[1]), .Btn_level(lv[1]));
  count_up_debounce #(.STABLE_CYCLES(1), .REPEAT_CYCLES(1)) dut2 (
    .Clk(clk), .Reset(rst), .Btn_in(btn), .Count_up(cu[2]), .Btn_level(lv[2]));

  always #5 clk = ~clk;

  task automatic model_step(input bit r, input bit b);
    bit s;
    s = m_s2;
    for (int i = 0; i < N; i++) m_cu[i] = 1'b0;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_lvl[i] = 0; m_run[i] = 0; m_rep[i] = 0;
      end
      m_s1 = 1'b0;
      m_s2 = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_lvl[i] == 0) begin
          if (s) begin
            m_run[i]++;
            if (m_run[i] == stab[i] + 1) begin
              m_lvl[i] = 1; m_cu[i] = 1'b1; m_run[i] = 0; m_rep[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end else begin
          if (!s) begin
            m_run[i]++;
            m_rep[i] = 0;
            if (m_run[i] == stab[i] + 1) begin
              m_lvl[i] = 0; m_run[i] = 0;
            end
          end else if (m_run[i] > 0) begin
            m_run[i] = 0; m_rep[i] = 0;
          end else if (rptc[i] != 0) begin
            if (m_rep[i] == rptc[i] - 1) begin
              m_cu[i] = 1'b1; m_rep[i] = 0;
            end else begin
              m_rep[i]++;
            end
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = b;
    end
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit b);
    rst = r;
    btn = b;
    @(posedge clk);
    model_step(r, b);
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("model_count_up[%0d]", i), int'(cu[i]), int'(m_cu[i]));
      check($sformatf("model_btn_level[%0d]", i), int'(lv[i]), m_lvl[i]);
    end
  endtask

  task automatic add(input bit r, input bit b, input bit c, input bit l, input int n);
    vec_t v;
    v.r = r; v.b = b; v.cu = c; v.lv = l;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    int c0;
    int c1;
    int last1;
    int hold;
    bit b;
    bit r;

    rst = 1'b1;
    btn = 1'b0;

    // Expected values for the STABLE=4, no-repeat instance.
    add(1'b1, 1'b1, 1'b0, 1'b0, 1);   // reset with button held
    add(1'b0, 1'b1, 1'b0, 1'b0, 6);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1);   // 7 edges after reset release
    add(1'b0, 1'b1, 1'b0, 1'b1, 3);
    add(1'b0, 1'b0, 1'b0, 1'b1, 6);   // release latency
    add(1'b0, 1'b0, 1'b0, 1'b0, 3);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1);   // bounce 1,0,1,0
    add(1'b0, 1'b0, 1'b0, 1'b0, 1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 6);   // final rise
    add(1'b0, 1'b1, 1'b1, 1'b1, 1);
    add(1'b0, 1'b1, 1'b0, 1'b1, 2);
    add(1'b0, 1'b0, 1'b0, 1'b1, 2);   // release bounce 0,0,1 then 0
    add(1'b0, 1'b1, 1'b0, 1'b1, 1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 6);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4);   // press aborted by reset in the window
    add(1'b1, 1'b0, 1'b0, 1'b0, 1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2);
    add(1'b0, 1'b1, 1'b0, 1'b0, 6);   // fresh press after reset
    add(1'b0, 1'b1, 1'b1, 1'b1, 1);
    add(1'b0, 1'b1, 1'b0, 1'b1, 2);
    add(1'b0, 1'b0, 1'b0, 1'b1, 6);
    add(1'b0, 1'b0, 1'b0, 1'b0, 4);

    foreach (vecs[k]) begin
      cyc(vecs[k].r, vecs[k].b);
      check($sformatf("table_count_up[%0d]", k), int'(cu[0]), int'(vecs[k].cu));
      check($sformatf("table_btn_level[%0d]", k), int'(lv[0]), int'(vecs[k].lv));
    end

    // Auto-repeat: 32-cycle hold gives 4 strobes with period 8, one without repeat.
    c0 = 0; c1 = 0; last1 = -1;
    for (int t = 0; t < 42; t++) begin
      cyc(1'b0, (t < 32) ? 1'b1 : 1'b0);
      if (cu[0]) c0++;
      if (cu[1]) begin
        if (last1 >= 0) check("repeat_period", t - last1, 8);
        last1 = t;
        c1++;
      end
    end
    check("repeat_pulses_norepeat", c0, 1);
    check("repeat_pulses_r8", c1, 4);
    check("repeat_level_released", int'(lv[1]), 0);

    // Randomised bouncing with occasional resets.
    b = 1'b0;
    hold = 0;
    for (int t = 0; t < 3000; t++) begin
      if (hold == 0) begin
        b = ~b;
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40))
                                            : int'($urandom_range(1, 6));
      end
      r = ($urandom_range(0, 199) == 0);
      cyc(r, b);
      hold--;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
